// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and stall controller for the 5-stage MIPS pipeline. It sequences
// the PC and the IF/ID and ID/EX registers, detects load-use hazards,
// squashes wrong-path instructions on a taken branch in EX, and tracks the
// multi-cycle mult/div unit so dependent ID instructions are held back.
//
// Ports
//   CLK, RESET         clock, asynchronous active-high reset
//   I_IFID_RS/RT       source fields of the ID instruction
//   I_IFID_UsesRT      ID instruction reads rt
//   I_IDEX_MemRead/RT  EX instruction is a load, and its destination
//   I_EX_BranchTaken   branch/jump in EX resolved taken
//   I_ID_MDStart       ID instruction is mult/multu/div/divu
//   I_ID_MDRead        ID instruction is mfhi/mflo
//   O_PC_Write         PC load enable
//   O_IFID_Write       IF/ID load enable
//   O_IFID_Flush       load IF/ID with a NOP
//   O_IDEX_Bubble      zero the control word entering ID/EX
//   O_MD_Busy          mult/div unit occupied
//   O_MD_Done          last busy cycle of the current mult/div
//   O_StallCount       saturating count of stalled cycles
module pipeline_hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  I_IFID_RS,
  input  logic [4:0]  I_IFID_RT,
  input  logic        I_IFID_UsesRT,
  input  logic        I_IDEX_MemRead,
  input  logic [4:0]  I_IDEX_RT,
  input  logic        I_EX_BranchTaken,
  input  logic        I_ID_MDStart,
  input  logic        I_ID_MDRead,
  output logic        O_PC_Write,
  output logic        O_IFID_Write,
  output logic        O_IFID_Flush,
  output logic        O_IDEX_Bubble,
  output logic        O_MD_Busy,
  output logic        O_MD_Done,
  output logic [15:0] O_StallCount
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STALL_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  md_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu_c;
  logic sh_c;
  logic stall_c;
  logic accept_c;

  // Load-use: r0 is never a real producer, so it cannot cause a stall.
  assign lu_c = I_IDEX_MemRead && (I_IDEX_RT != 5'd0) &&
                ((I_IDEX_RT == I_IFID_RS) ||
                 (I_IFID_UsesRT && (I_IDEX_RT == I_IFID_RT)));

  // Structural: mult/div unit occupied, including its final (done) cycle.
  assign sh_c     = (state_q == ST_BUSY) && (I_ID_MDStart || I_ID_MDRead);
  assign stall_c  = (lu_c || sh_c) && !I_EX_BranchTaken;
  assign accept_c = I_ID_MDStart && !stall_c && !I_EX_BranchTaken;

  // Pipeline control; branch flush outranks stall, reset forces a bubble.
  always_comb begin
    O_PC_Write    = 1'b1;
    O_IFID_Write  = 1'b1;
    O_IFID_Flush  = 1'b0;
    O_IDEX_Bubble = 1'b0;
    if (RESET) begin
      O_PC_Write    = 1'b0;
      O_IFID_Write  = 1'b0;
      O_IFID_Flush  = 1'b1;
      O_IDEX_Bubble = 1'b1;
    end else if (I_EX_BranchTaken) begin
      O_IFID_Flush  = 1'b1;
      O_IDEX_Bubble = 1'b1;
    end else if (stall_c) begin
      O_PC_Write    = 1'b0;
      O_IFID_Write  = 1'b0;
      O_IDEX_Bubble = 1'b1;
    end
  end

  // Mult/div next state; a committed op keeps counting through branches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(MD_LATENCY - 1);
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturating stall counter; branch-flush cycles are excluded by stall_c.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != {STALL_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign O_MD_Busy    = (state_q == ST_BUSY);
  assign O_MD_Done    = (state_q == ST_BUSY) && (cnt_q == '0);
  assign O_StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MD_LATENCY=4.
// Inputs change 1 time unit after each rising edge; outputs are checked
// 1 time unit after the inputs settle, well away from the next edge.
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  I_IFID_RS, I_IFID_RT, I_IDEX_RT;
  logic        I_IFID_UsesRT, I_IDEX_MemRead, I_EX_BranchTaken;
  logic        I_ID_MDStart, I_ID_MDRead;
  logic        O_PC_Write, O_IFID_Write, O_IFID_Flush, O_IDEX_Bubble;
  logic        O_MD_Busy, O_MD_Done;
  logic [15:0] O_StallCount;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  pipeline_hazard_ctrl #(.MD_LATENCY(4)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .I_IFID_RS       (I_IFID_RS),
    .I_IFID_RT       (I_IFID_RT),
    .I_IFID_UsesRT   (I_IFID_UsesRT),
    .I_IDEX_MemRead  (I_IDEX_MemRead),
    .I_IDEX_RT       (I_IDEX_RT),
    .I_EX_BranchTaken(I_EX_BranchTaken),
    .I_ID_MDStart    (I_ID_MDStart),
    .I_ID_MDRead     (I_ID_MDRead),
    .O_PC_Write      (O_PC_Write),
    .O_IFID_Write    (O_IFID_Write),
    .O_IFID_Flush    (O_IFID_Flush),
    .O_IDEX_Bubble   (O_IDEX_Bubble),
    .O_MD_Busy       (O_MD_Busy),
    .O_MD_Done       (O_MD_Done),
    .O_StallCount    (O_StallCount)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble}
  task automatic chk_ctl(input string tag, input logic [3:0] exp);
    chk(tag, 32'({O_PC_Write, O_IFID_Write, O_IFID_Flush, O_IDEX_Bubble}), 32'(exp));
  endtask

  task automatic clear_inputs();
    I_IFID_RS = 5'd0; I_IFID_RT = 5'd0; I_IFID_UsesRT = 1'b0;
    I_IDEX_MemRead = 1'b0; I_IDEX_RT = 5'd0; I_EX_BranchTaken = 1'b0;
    I_ID_MDStart = 1'b0; I_ID_MDRead = 1'b0;
  endtask

  task automatic set_lu();
    I_IDEX_MemRead = 1'b1; I_IDEX_RT = 5'd8; I_IFID_RS = 5'd8;
  endtask

  localparam logic [3:0] CTL_RUN   = 4'b1100;
  localparam logic [3:0] CTL_STALL = 4'b0001;
  localparam logic [3:0] CTL_FLUSH = 4'b1111;
  localparam logic [3:0] CTL_RST   = 4'b0011;

  initial begin
    clear_inputs();
    RESET = 1'b1;
    tick();
    // Reset values held even with hazard/branch inputs active
    set_lu();
    I_ID_MDStart = 1'b1;
    #1;
    chk_ctl("rst_ctl", CTL_RST);
    chk("rst_busy", 32'(O_MD_Busy), 32'd0);
    chk("rst_done", 32'(O_MD_Done), 32'd0);
    tick();
    chk("rst_cnt", 32'(O_StallCount), 32'd0);
    chk("rst_busy_hold", 32'(O_MD_Busy), 32'd0);
    RESET = 1'b0;
    clear_inputs();
    #1;
    chk_ctl("run_idle", CTL_RUN);

    // Load-use on rs: one stall cycle, then the load moves to MEM
    set_lu();
    #1;
    chk_ctl("lu_stall", CTL_STALL);
    tick(); exp_cnt++;
    clear_inputs();
    #1;
    chk_ctl("lu_after", CTL_RUN);
    chk("lu_cnt", 32'(O_StallCount), 32'(exp_cnt));

    // r0 destination never stalls
    I_IDEX_MemRead = 1'b1; I_IDEX_RT = 5'd0; I_IFID_RS = 5'd0;
    I_IFID_RT = 5'd0; I_IFID_UsesRT = 1'b1;
    #1;
    chk_ctl("lu_r0", CTL_RUN);
    tick();
    chk("lu_r0_cnt", 32'(O_StallCount), 32'(exp_cnt));

    // rt dependency only matters when rt is a source
    clear_inputs();
    I_IDEX_MemRead = 1'b1; I_IDEX_RT = 5'd9; I_IFID_RT = 5'd9; I_IFID_RS = 5'd3;
    #1;
    chk_ctl("rt_unused", CTL_RUN);
    I_IFID_UsesRT = 1'b1;
    #1;
    chk_ctl("rt_used", CTL_STALL);
    tick(); exp_cnt++;
    clear_inputs();
    #1;
    chk("rt_cnt", 32'(O_StallCount), 32'(exp_cnt));

    // Mult/div accepted at edge 0; mfhi held in ID from cycle 1
    I_ID_MDStart = 1'b1;
    #1;
    chk_ctl("md_accept", CTL_RUN);
    tick();
    I_ID_MDStart = 1'b0; I_ID_MDRead = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("md_busy_c%0d", c), 32'(O_MD_Busy), 32'd1);
      chk($sformatf("md_done_c%0d", c), 32'(O_MD_Done), 32'(c == 4));
      chk_ctl($sformatf("md_read_stall_c%0d", c), CTL_STALL);
      tick(); exp_cnt++;
    end
    #1;
    chk("md_idle_c5", 32'(O_MD_Busy), 32'd0);
    chk_ctl("md_read_go_c5", CTL_RUN);
    chk("md_cnt", 32'(O_StallCount), 32'(exp_cnt));
    tick();
    clear_inputs();

    // Back-to-back MDStart: stalls through the done cycle, accepted with no gap
    I_ID_MDStart = 1'b1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk_ctl($sformatf("md2_stall_c%0d", c), CTL_STALL);
      tick(); exp_cnt++;
    end
    #1;
    chk("md2_idle", 32'(O_MD_Busy), 32'd0);
    chk_ctl("md2_accept", CTL_RUN);
    tick();
    I_ID_MDStart = 1'b0;
    // Branch while busy: op keeps counting
    I_EX_BranchTaken = 1'b1;
    #1;
    chk("md2_busy", 32'(O_MD_Busy), 32'd1);
    chk_ctl("md2_br_flush", CTL_FLUSH);
    tick();
    I_EX_BranchTaken = 1'b0;
    tick(); tick();
    #1;
    chk("md2_br_done", 32'(O_MD_Done), 32'd1);
    tick();
    #1;
    chk("md2_br_idle", 32'(O_MD_Busy), 32'd0);
    chk("md2_cnt", 32'(O_StallCount), 32'(exp_cnt));

    // Branch beats load-use and is not counted
    set_lu(); I_EX_BranchTaken = 1'b1;
    #1;
    chk_ctl("br_lu", CTL_FLUSH);
    tick();
    chk("br_lu_cnt", 32'(O_StallCount), 32'(exp_cnt));
    clear_inputs();
    // Flushed MDStart never starts the unit
    I_ID_MDStart = 1'b1; I_EX_BranchTaken = 1'b1;
    tick();
    clear_inputs();
    #1;
    chk("br_md_busy", 32'(O_MD_Busy), 32'd0);

    // Reset mid-op at CNT=2 aborts immediately
    I_ID_MDStart = 1'b1;
    tick();
    I_ID_MDStart = 1'b0;
    tick();
    set_lu();
    RESET = 1'b1;
    #1;
    chk("rmid_busy", 32'(O_MD_Busy), 32'd0);
    chk("rmid_cnt", 32'(O_StallCount), 32'd0);
    chk_ctl("rmid_ctl", CTL_RST);
    tick();
    chk_ctl("rmid_ctl_hold", CTL_RST);
    RESET = 1'b0;
    clear_inputs();
    exp_cnt = 0;
    I_ID_MDStart = 1'b1;
    #1;
    chk_ctl("rmid_idle_accept", CTL_RUN);
    tick();
    I_ID_MDStart = 1'b0;
    #1;
    chk("rmid_restart_busy", 32'(O_MD_Busy), 32'd1);
    chk("rmid_restart_done", 32'(O_MD_Done), 32'd0);
    repeat (4) tick();

    // Saturation: 70000 consecutive load-use stall cycles from zero
    set_lu();
    repeat (65534) tick();
    chk("sat_fffe", 32'(O_StallCount), 32'h0000_FFFE);
    tick();
    chk("sat_ffff", 32'(O_StallCount), 32'h0000_FFFF);
    repeat (4465) tick();
    chk("sat_hold", 32'(O_StallCount), 32'h0000_FFFF);
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
